// File: rtl/spm_pkg.sv
// Shared definitions for the scratchpad port arbiter.
//   spm_max_address() : highest 32-bit word address for a given scratchpad size in KiB
//   arb_state_e       : arbiter FSM states (INIT zero-fills the memory, RUN serves requests)
//   SPM_WORD_BYTES    : bytes per scratchpad word
package spm_pkg;

   localparam int unsigned SPM_WORD_BYTES = 4;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } arb_state_e;

   function automatic int unsigned spm_max_address(input int unsigned memsize_kb);
      return (memsize_kb * 1024) / SPM_WORD_BYTES - 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot round-robin picker.
//   req_i   : request vector
//   ptr_i   : index with the highest priority this cycle (must be < N)
//   gnt_o   : one-hot grant, first set request at or above ptr_i, wrapping
//   idx_o   : binary index of the grant (0 when nothing is granted)
//   valid_o : at least one request is set
module rr_arbiter #(
   parameter int unsigned N    = 4,
   parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req_i,
   input  logic [IdxW-1:0] ptr_i,
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] idx_o,
   output logic            valid_o
);

   always_comb begin
      int unsigned j;
      j       = 0;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         j = int'(ptr_i) + k;
         if (j >= N) begin
            j = j - N;
         end
         if (!valid_o && req_i[j]) begin
            valid_o  = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IdxW'(j);
         end
      end
   end

endmodule

// File: rtl/spm_port_arbiter.sv
// Round-robin arbiter sharing one scratchpad DPRAM port between NUM_REQ requesters.
// After reset it optionally zero-fills the whole scratchpad (INIT) before serving requests (RUN).
// A granted request is issued to the DPRAM in the same cycle; its response (one-hot tag plus
// registered DPRAM data) appears on the following cycle. Writes respond with write-through data.
//
// Optional build macro SPM_ARB_BOUNDS_CHECK_EN: requests above the scratchpad size are granted
// but not issued, respond with rsp_err_o=1 / zero data, and bump the saturating err_cnt_q.
//
// Ports:
//   clk_i, rst_ni               : clock, asynchronous active-low reset
//   req_valid_i / req_ready_o   : per-requester handshake (ready is a one-hot grant)
//   req_we_i, req_addr_i,
//   req_wdata_i                 : per-requester command, flattened by requester index
//   rsp_valid_o, rsp_rdata_o,
//   rsp_err_o                   : one-hot response strobe, shared data, out-of-range flag
//   init_done_o                 : high once in RUN
//   mem_en_o, mem_we_o,
//   mem_addr_o, mem_din_o       : DPRAM port command
//   mem_dout_i                  : DPRAM read data, registered one cycle after issue
module spm_port_arbiter
   import spm_pkg::*;
#(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned ADDR_W        = 32,
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned MEMSIZE_KB    = 128,
   parameter int unsigned INIT_ON_RESET = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [NUM_REQ-1:0]        req_we_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]        rsp_valid_o,
   output logic [DATA_W-1:0]         rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      init_done_o,
   output logic                      mem_en_o,
   output logic                      mem_we_o,
   output logic [ADDR_W-1:0]         mem_addr_o,
   output logic [DATA_W-1:0]         mem_din_o,
   input  logic [DATA_W-1:0]         mem_dout_i
);

   localparam int unsigned MaxAddress = spm_max_address(MEMSIZE_KB);
   localparam int unsigned CntW       = $clog2(MaxAddress + 1);
   localparam int unsigned IdxW       = $clog2(NUM_REQ);

   arb_state_e           state_q, state_d;
   logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [CntW-1:0]      init_cnt_q, init_cnt_d;
   logic                 init_done_q;
   logic [NUM_REQ-1:0]   tag_q, tag_d;

   logic [NUM_REQ-1:0]   gnt;
   logic [IdxW-1:0]      gnt_idx;
   logic                 gnt_any;

   logic                 g_we;
   logic [ADDR_W-1:0]    g_addr;
   logic [DATA_W-1:0]    g_wdata;
   logic                 g_oob;

   rr_arbiter #(
      .N    (NUM_REQ),
      .IdxW (IdxW)
   ) u_rr_arbiter (
      .req_i   (req_valid_i),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (gnt),
      .idx_o   (gnt_idx),
      .valid_o (gnt_any)
   );

   assign g_we    = req_we_i[gnt_idx];
   assign g_addr  = req_addr_i[gnt_idx*ADDR_W +: ADDR_W];
   assign g_wdata = req_wdata_i[gnt_idx*DATA_W +: DATA_W];

`ifdef SPM_ARB_BOUNDS_CHECK_EN
   logic        err_q, err_d;
   logic [15:0] err_cnt_q;

   assign g_oob = (g_addr > ADDR_W'(MaxAddress));
`else
   // Upper address bits pass straight through; the DPRAM wraps or truncates them.
   assign g_oob = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      init_cnt_d  = init_cnt_q;
      tag_d       = '0;
`ifdef SPM_ARB_BOUNDS_CHECK_EN
      err_d       = 1'b0;
`endif
      req_ready_o = '0;
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_din_o   = '0;

      if (state_q == INIT) begin
         mem_en_o   = 1'b1;
         mem_we_o   = 1'b1;
         mem_addr_o = ADDR_W'(init_cnt_q);
         init_cnt_d = init_cnt_q + 1'b1;
         if (init_cnt_q == CntW'(MaxAddress)) begin
            init_cnt_d = '0;
            state_d    = RUN;
         end
      end else if (gnt_any) begin
         // ready is a subset of valid, so any grant is a transfer
         req_ready_o = gnt;
         mem_en_o    = !g_oob;
         mem_we_o    = g_we && !g_oob;
         mem_addr_o  = g_addr;
         mem_din_o   = g_wdata;
         rr_ptr_d    = (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
         tag_d       = gnt;
`ifdef SPM_ARB_BOUNDS_CHECK_EN
         err_d       = g_oob;
`endif
      end

      // Keep the memory port and handshake quiet while reset is asserted.
      if (!rst_ni) begin
         req_ready_o = '0;
         mem_en_o    = 1'b0;
         mem_we_o    = 1'b0;
         mem_addr_o  = '0;
         mem_din_o   = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= (INIT_ON_RESET != 0) ? INIT : RUN;
         rr_ptr_q    <= '0;
         init_cnt_q  <= '0;
         init_done_q <= 1'b0;
         tag_q       <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         init_cnt_q  <= init_cnt_d;
         init_done_q <= (state_d == RUN);
         tag_q       <= tag_d;
      end
   end

`ifdef SPM_ARB_BOUNDS_CHECK_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         err_q <= err_d;
         if (err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
         end
      end
   end

   assign rsp_err_o   = err_q;
   assign rsp_rdata_o = err_q ? '0 : mem_dout_i;
`else
   assign rsp_err_o   = 1'b0;
   assign rsp_rdata_o = mem_dout_i;
`endif

   assign rsp_valid_o = tag_q;
   assign init_done_o = init_done_q;

endmodule

// File: tb/tb_spm_port_arbiter.sv
module tb_spm_port_arbiter;

   localparam int unsigned NR  = 4;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned MAX = 255;
`ifdef SPM_ARB_BOUNDS_CHECK_EN
   localparam bit BC = 1'b1;
`else
   localparam bit BC = 1'b0;
`endif

   typedef struct {
      logic [NR-1:0] v;
      logic [DW-1:0] d;
      logic          e;
   } rsp_t;

   logic              clk;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     req_we;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic [NR-1:0]     rsp_valid;
   logic [DW-1:0]     rsp_rdata;
   logic              rsp_err;
   logic              init_done;
   logic              mem_en;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_din;
   logic [DW-1:0]     mem_dout;

   logic [DW-1:0]     mem [0:MAX];
   logic [DW-1:0]     shadow [0:MAX];
   rsp_t              exp_q[$];
   int                checks;
   int                failures;

   spm_port_arbiter #(
      .NUM_REQ       (NR),
      .ADDR_W        (AW),
      .DATA_W        (DW),
      .MEMSIZE_KB    (1),
      .INIT_ON_RESET (1)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .init_done_o (init_done),
      .mem_en_o    (mem_en),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_din_o   (mem_din),
      .mem_dout_i  (mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DPRAM port model: registered read, write-through on writes, 256 words.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_din;
            mem_dout           <= mem_din;
         end else begin
            mem_dout <= mem[mem_addr[7:0]];
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      req_valid[i]           = v;
      req_we[i]              = we;
      req_addr[i*AW +: AW]   = a;
      req_wdata[i*DW +: DW]  = d;
   endtask

   // One RUN cycle: check the response due now, check the grant, queue the expected response.
   task automatic do_cycle(input logic [NR-1:0] exp_rdy);
      rsp_t          r;
      int            g;
      logic [AW-1:0] a;
      logic          oob;
      @(negedge clk);
      if (exp_q.size() > 0) begin
         r = exp_q.pop_front();
         chk("rsp_valid", 64'(rsp_valid), 64'(r.v));
         chk("rsp_rdata", 64'(rsp_rdata), 64'(r.d));
         chk("rsp_err", 64'(rsp_err), 64'(r.e));
      end else begin
         chk("rsp_idle", 64'(rsp_valid), 64'(0));
      end
      chk("init_done", 64'(init_done), 64'(1));
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (exp_rdy != '0) begin
         g = 0;
         for (int i = 0; i < NR; i++) if (exp_rdy[i]) g = i;
         a   = req_addr[g*AW +: AW];
         oob = BC && (a > AW'(MAX));
         chk("mem_en", 64'(mem_en), 64'(!oob));
         if (!oob) begin
            chk("mem_addr", 64'(mem_addr), 64'(a));
            chk("mem_we", 64'(mem_we), 64'(req_we[g]));
         end
         r.v = exp_rdy;
         r.e = oob;
         if (oob) begin
            r.d = '0;
         end else if (req_we[g]) begin
            shadow[a[7:0]] = req_wdata[g*DW +: DW];
            r.d            = req_wdata[g*DW +: DW];
         end else begin
            r.d = shadow[a[7:0]];
         end
         exp_q.push_back(r);
      end else begin
         chk("mem_en_idle", 64'(mem_en), 64'(0));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      for (int i = 0; i <= MAX; i++) begin
         mem[i]    = $urandom;
         shadow[i] = '0;
      end
      rst_n     = 1'b0;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      // All four requesters wait through reset and INIT.
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(32'h20 + i), '0);

      // Reset state
      @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_ctl", {mem_en, mem_we, rsp_valid, rsp_err, init_done}, 64'(0));
      chk("rst_addr_din", {mem_addr, mem_din}, 64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Zero-fill sweep: 256 writes, no grants
      for (int k = 0; k <= MAX; k++) begin
         @(negedge clk);
         chk("init_addr", 64'(mem_addr), 64'(k));
         chk("init_ctl", {mem_en, mem_we, req_ready, init_done, rsp_valid, mem_din},
             {2'b11, 4'b0, 1'b0, 4'b0, 32'b0});
         @(posedge clk);
         #1;
      end

      // Fairness from rr_ptr=0, reads of zero-filled words
      for (int k = 0; k < 8; k++) do_cycle(NR'(1) << (k % NR));
      for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, '0, '0);

      // Write then read, requester 0
      set_req(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
      do_cycle(4'b0001);
      set_req(0, 1'b1, 1'b0, 32'h10, '0);
      do_cycle(4'b0001);
      set_req(0, 1'b0, 1'b0, '0, '0);
      do_cycle(4'b0000);

      // Move rr_ptr to 2, then sparse rotation 3,1,3,1
      set_req(1, 1'b1, 1'b0, 32'h10, '0);
      do_cycle(4'b0010);
      set_req(3, 1'b1, 1'b1, 32'h40, 32'hA5A50003);
      do_cycle(4'b1000);
      do_cycle(4'b0010);
      do_cycle(4'b1000);
      do_cycle(4'b0010);
      set_req(1, 1'b0, 1'b0, '0, '0);
      set_req(3, 1'b0, 1'b0, '0, '0);
      do_cycle(4'b0000);

      // Last valid word, then first address past the end
      set_req(0, 1'b1, 1'b0, AW'(MAX), '0);
      do_cycle(4'b0001);
      set_req(0, 1'b1, 1'b0, AW'(MAX + 1), '0);
      do_cycle(4'b0001);
      set_req(0, 1'b0, 1'b0, '0, '0);
      do_cycle(4'b0000);
`ifdef SPM_ARB_BOUNDS_CHECK_EN
      chk("err_cnt", 64'(dut.err_cnt_q), 64'(1));
`endif

      // Reset in the cycle after a read grant drops the response and restarts INIT
      set_req(0, 1'b1, 1'b0, 32'h10, '0);
      do_cycle(4'b0001);
      rst_n = 1'b0;
      void'(exp_q.pop_front());
      @(negedge clk);
      chk("midrst_rsp", 64'(rsp_valid), 64'(0));
      chk("midrst_out", {req_ready, mem_en, init_done}, 64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("reinit_addr", 64'(mem_addr), 64'(k));
         chk("reinit_ctl", {mem_en, mem_we, req_ready, init_done, rsp_valid},
             {2'b11, 4'b0, 1'b0, 4'b0});
         @(posedge clk);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
